// File: rtl/qcldpc_info_blk_packer.sv
// rtl/qcldpc_info_blk_packer.sv - packs an IN_W-bit info stream into Z-bit QC-LDPC info blocks
module qcldpc_info_blk_packer #(
   parameter int NUM_Z            = 3,
   parameter int MAX_Z            = 81,
   parameter int NUM_INFO_BLKS    = 20,
   parameter int IN_W             = 9,
   parameter int Z_VALUES [NUM_Z] = '{27, 54, 81}
) (
   input  logic                             CLK,
   input  logic                             rst,
   input  logic [NUM_Z-1:0]                 req_z,
   input  logic [IN_W-1:0]                  s_data,
   input  logic                             s_valid,
   output logic                             s_ready,
   output logic [MAX_Z-1:0]                 blk_data,
   output logic                             blk_valid,
   input  logic                             blk_ready,
   output logic [$clog2(NUM_INFO_BLKS)-1:0] blk_idx,
   output logic                             blk_first,
   output logic                             blk_last,
   output logic [NUM_Z-1:0]                 blk_z,
   output logic                             cfg_err
);
   localparam int IDX_W   = $clog2(NUM_INFO_BLKS);
   localparam int MAX_WPB = MAX_Z / IN_W;
   localparam int CNT_W   = $clog2(MAX_WPB + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INFO_BLKS - 1);

   for (genvar g = 0; g < NUM_Z; g++) begin : g_zchk
      if ((Z_VALUES[g] % IN_W) != 0 || Z_VALUES[g] > MAX_Z) begin : g_bad
         $fatal(1, "Z_VALUES entry %0d is not a multiple of IN_W or exceeds MAX_Z", g);
      end
   end

   typedef enum logic {IDLE, FILL} state_t;

   state_t             state_q, state_d;
   logic [NUM_Z-1:0]   cur_z_q, cur_z_d;
   logic [CNT_W-1:0]   wpb_q, wpb_d;
   logic [CNT_W-1:0]   w_cnt_q, w_cnt_d;
   logic [IDX_W-1:0]   b_cnt_q, b_cnt_d;
   logic               pending_q, pending_d;
   logic [MAX_Z-1:0]   fill_q, fill_d;
   logic [MAX_Z-1:0]   blk_data_q, blk_data_d;
   logic               blk_valid_q, blk_valid_d;
   logic [IDX_W-1:0]   blk_idx_q, blk_idx_d;
   logic               blk_first_q, blk_first_d;
   logic               blk_last_q, blk_last_d;
   logic [NUM_Z-1:0]   blk_z_q, blk_z_d;
   logic               cfg_err_q, cfg_err_d;

   logic               accept, fill_done, xfer, slot_free;
   logic [MAX_Z-1:0]   merged, new_blk, z_mask;
   logic [CNT_W-1:0]   wpb_sel;
   int                 zval;

   always_comb begin
      state_d     = state_q;
      cur_z_d     = cur_z_q;
      wpb_d       = wpb_q;
      w_cnt_d     = w_cnt_q;
      b_cnt_d     = b_cnt_q;
      pending_d   = pending_q;
      fill_d      = fill_q;
      blk_data_d  = blk_data_q;
      blk_valid_d = blk_valid_q;
      blk_idx_d   = blk_idx_q;
      blk_first_d = blk_first_q;
      blk_last_d  = blk_last_q;
      blk_z_d     = blk_z_q;
      cfg_err_d   = 1'b0;
      accept      = 1'b0;
      fill_done   = 1'b0;
      xfer        = 1'b0;
      new_blk     = fill_q;
      slot_free   = !blk_valid_q || blk_ready;

      wpb_sel = '0;
      zval    = 0;
      for (int i = 0; i < NUM_Z; i++) begin
         if (req_z[i])   wpb_sel = CNT_W'(Z_VALUES[i] / IN_W);
         if (cur_z_q[i]) zval    = Z_VALUES[i];
      end
      for (int b = 0; b < MAX_Z; b++) z_mask[b] = (b < zval);

      // The word being accepted this cycle, merged into its slot of the fill buffer
      merged = fill_q;
      for (int k = 0; k < MAX_WPB; k++) begin
         if (w_cnt_q == CNT_W'(k)) merged[k*IN_W +: IN_W] = s_data;
      end

      if (blk_valid_q && blk_ready) blk_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (s_valid) begin
               if ($onehot(req_z)) begin
                  cur_z_d = req_z;
                  wpb_d   = wpb_sel;
                  w_cnt_d = '0;
                  b_cnt_d = '0;
                  state_d = FILL;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         FILL: begin
            accept    = s_valid && !pending_q;
            fill_done = accept && (w_cnt_q == wpb_q - CNT_W'(1));
            if (accept) fill_d = merged;
            if (pending_q) begin
               xfer = slot_free;
            end else if (fill_done) begin
               if (slot_free) begin
                  xfer    = 1'b1;
                  new_blk = merged;
               end else begin
                  pending_d = 1'b1;
               end
            end else if (accept) begin
               w_cnt_d = w_cnt_q + CNT_W'(1);
            end
            if (xfer) begin
               pending_d   = 1'b0;
               w_cnt_d     = '0;
               b_cnt_d     = b_cnt_q + IDX_W'(1);
               blk_data_d  = new_blk & z_mask;
               blk_valid_d = 1'b1;
               blk_idx_d   = b_cnt_q;
               blk_first_d = (b_cnt_q == '0);
               blk_last_d  = (b_cnt_q == LAST_IDX);
               blk_z_d     = cur_z_q;
               if (b_cnt_q == LAST_IDX) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_z_q     <= '0;
         wpb_q       <= '0;
         w_cnt_q     <= '0;
         b_cnt_q     <= '0;
         pending_q   <= 1'b0;
         fill_q      <= '0;
         blk_data_q  <= '0;
         blk_valid_q <= 1'b0;
         blk_idx_q   <= '0;
         blk_first_q <= 1'b0;
         blk_last_q  <= 1'b0;
         blk_z_q     <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_z_q     <= cur_z_d;
         wpb_q       <= wpb_d;
         w_cnt_q     <= w_cnt_d;
         b_cnt_q     <= b_cnt_d;
         pending_q   <= pending_d;
         fill_q      <= fill_d;
         blk_data_q  <= blk_data_d;
         blk_valid_q <= blk_valid_d;
         blk_idx_q   <= blk_idx_d;
         blk_first_q <= blk_first_d;
         blk_last_q  <= blk_last_d;
         blk_z_q     <= blk_z_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign s_ready   = (state_q == FILL) && !pending_q;
   assign blk_data  = blk_data_q;
   assign blk_valid = blk_valid_q;
   assign blk_idx   = blk_idx_q;
   assign blk_first = blk_first_q;
   assign blk_last  = blk_last_q;
   assign blk_z     = blk_z_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_qcldpc_info_blk_packer.sv
// tb/tb_qcldpc_info_blk_packer.sv - self-checking bench for qcldpc_info_blk_packer
module tb_qcldpc_info_blk_packer;
   logic        CLK;
   logic        rst;
   logic [2:0]  req_z;
   logic [8:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic [80:0] blk_data;
   logic        blk_valid;
   logic        blk_ready;
   logic [4:0]  blk_idx;
   logic        blk_first;
   logic        blk_last;
   logic [2:0]  blk_z;
   logic        cfg_err;

   qcldpc_info_blk_packer dut (
      .CLK(CLK), .rst(rst), .req_z(req_z), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_idx(blk_idx), .blk_first(blk_first), .blk_last(blk_last), .blk_z(blk_z),
      .cfg_err(cfg_err)
   );

   typedef struct packed {
      logic [80:0] data;
      logic [4:0]  idx;
      logic        first;
      logic        last;
      logic [2:0]  z;
   } blk_t;

   int   ZV [3] = '{27, 54, 81};
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_acc = 0;
   int   cyc = 0;
   int   acc_cyc [$];
   blk_t got_q [$];
   blk_t exp_q [$];
   logic [8:0] cw_words [$];
   bit   rdy_mode = 0;
   logic rdy_val = 1'b1;
   logic rnd_q = 1'b0;

   assign blk_ready = rdy_mode ? rnd_q : rdy_val;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      #1 rnd_q = 1'($urandom_range(0, 1));
   end

   // Handshakes are observed mid-cycle; inputs only move just after rising edges
   always @(negedge CLK) begin
      blk_t b;
      if (blk_valid && blk_ready) begin
         b.data = blk_data; b.idx = blk_idx; b.first = blk_first; b.last = blk_last; b.z = blk_z;
         got_q.push_back(b);
      end
      if (s_valid && s_ready) begin
         n_acc = n_acc + 1;
         acc_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [80:0] got, input logic [80:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic gen_words(input int zi, input bit incr, input int base);
      cw_words.delete();
      for (int i = 0; i < 20 * (ZV[zi] / 9); i++)
         cw_words.push_back(incr ? 9'(base + i) : 9'($urandom));
   endtask

   // Reference: block b holds words b*WPB .. b*WPB+WPB-1, word j weighted by 2^(9j)
   task automatic model_cw(input int zi);
      int   wpb;
      blk_t e;
      wpb = ZV[zi] / 9;
      for (int b = 0; b < 20; b++) begin
         e.data = '0;
         for (int j = 0; j < wpb; j++)
            e.data = e.data + (81'(cw_words[b*wpb + j]) << (9 * j));
         e.idx   = 5'(b);
         e.first = (b == 0);
         e.last  = (b == 19);
         e.z     = 3'(1 << zi);
         exp_q.push_back(e);
      end
   endtask

   task automatic push_word(input logic [8:0] d);
      bit ok;
      int t;
      ok = 0;
      t  = 0;
      s_data  = d;
      s_valid = 1'b1;
      while (!ok && t < 5000) begin
         @(negedge CLK);
         ok = s_ready;
         @(posedge CLK);
         #1;
         t++;
      end
      if (!ok) begin
         n_err++;
         $display("FAIL push_timeout observed=no_accept expected=accept word=%0h", d);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
         $fatal(1, "input word never accepted");
      end
   endtask

   task automatic run_cw(input int zi, input bit rnd, input bit hold);
      model_cw(zi);
      req_z = 3'(1 << zi);
      foreach (cw_words[i]) begin
         if (rnd) begin
            while ($urandom_range(0, 99) >= 70) begin
               s_valid = 1'b0;
               step();
            end
         end
         push_word(cw_words[i]);
         if (rnd && i == 0) req_z = 3'($urandom_range(0, 7));
      end
      if (!hold) s_valid = 1'b0;
   endtask

   task automatic wait_blocks();
      int t;
      t = 0;
      while (got_q.size() < exp_q.size() && t < 20000) begin
         step();
         t++;
      end
      repeat (4) step();
   endtask

   task automatic compare_all(input string tag);
      blk_t g, e;
      wait_blocks();
      chk({tag, "_count"}, 81'(got_q.size()), 81'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_data"},  g.data,  e.data);
         chk({tag, "_idx"},   81'(g.idx),   81'(e.idx));
         chk({tag, "_first"}, 81'(g.first), 81'(e.first));
         chk({tag, "_last"},  81'(g.last),  81'(e.last));
         chk({tag, "_z"},     81'(g.z),     81'(e.z));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s_ready"},   81'(s_ready),   81'(0));
      chk({tag, "_blk_valid"}, 81'(blk_valid), 81'(0));
      chk({tag, "_blk_data"},  blk_data,       81'(0));
      chk({tag, "_blk_idx"},   81'(blk_idx),   81'(0));
      chk({tag, "_blk_first"}, 81'(blk_first), 81'(0));
      chk({tag, "_blk_last"},  81'(blk_last),  81'(0));
      chk({tag, "_blk_z"},     81'(blk_z),     81'(0));
      chk({tag, "_cfg_err"},   81'(cfg_err),   81'(0));
   endtask

   initial begin
      int n0;
      rst = 1'b1; req_z = 3'b000; s_data = '0; s_valid = 1'b0;
      #12;
      chk_all_zero("reset");
      step();
      rst = 1'b0;
      step();

      // Z=27, incrementing data, consumer always ready
      gen_words(0, 1, 0);
      run_cw(0, 0, 0);
      wait_blocks();
      chk("z27_blk0_const", got_q[0].data, 81'h80200);
      chk("z27_blk1_const", got_q[1].data, 81'({9'd5, 9'd4, 9'd3}));
      compare_all("z27");

      // Z=81 immediately followed by Z=54, one idle cycle between them
      acc_cyc.delete();
      gen_words(2, 0, 0);
      run_cw(2, 0, 1);
      gen_words(1, 0, 0);
      run_cw(1, 0, 0);
      wait_blocks();
      chk("b2b_accepts", 81'(acc_cyc.size()), 81'(300));
      chk("b2b_sustained", 81'(acc_cyc[179] - acc_cyc[0]), 81'(179));
      chk("b2b_idle_gap", 81'(acc_cyc[180] - acc_cyc[179]), 81'(2));
      compare_all("b2b");

      // Backpressure from block 0 onward
      rdy_val = 1'b0;
      gen_words(0, 1, 100);
      model_cw(0);
      req_z = 3'b001;
      for (int i = 0; i < 6; i++) push_word(cw_words[i]);
      s_valid = 1'b0;
      @(negedge CLK);
      chk("bp_s_ready_low", 81'(s_ready), 81'(0));
      chk("bp_valid", 81'(blk_valid), 81'(1));
      chk("bp_hold_data", blk_data, exp_q[0].data);
      chk("bp_hold_idx", 81'(blk_idx), 81'(0));
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge CLK);
         chk("bp_stable_data", blk_data, exp_q[0].data);
         chk("bp_stable_s_ready", 81'(s_ready), 81'(0));
      end
      step();
      rdy_val = 1'b1;
      @(negedge CLK);
      chk("bp_pending_before_release", 81'(s_ready), 81'(0));
      step();
      @(negedge CLK);
      chk("bp_s_ready_back", 81'(s_ready), 81'(1));
      chk("bp_blk1_idx", 81'(blk_idx), 81'(1));
      chk("bp_blk1_data", blk_data, exp_q[1].data);
      step();
      for (int i = 6; i < 60; i++) push_word(cw_words[i]);
      s_valid = 1'b0;
      compare_all("bp");

      // Multi-hot request rejected for three cycles, then a normal codeword
      n0 = n_acc;
      req_z = 3'b011; s_data = 9'h1aa; s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (i == 2) req_z = 3'b001;
         @(negedge CLK);
         chk("cfg_err_pulse", 81'(cfg_err), 81'(1));
         chk("cfg_no_accept", 81'(n_acc), 81'(n0));
      end
      step();
      gen_words(0, 0, 0);
      run_cw(0, 0, 0);
      compare_all("after_cfg");

      // Reset after word 40 of a Z=27 codeword
      gen_words(0, 1, 200);
      model_cw(0);
      repeat (7) void'(exp_q.pop_back());
      req_z = 3'b001;
      for (int i = 0; i <= 40; i++) push_word(cw_words[i]);
      s_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      step();
      rst = 1'b0;
      compare_all("pre_rst");
      gen_words(0, 1, 300);
      run_cw(0, 0, 0);
      compare_all("post_rst");

      // Random traffic and backpressure over 10 mixed-Z codewords
      rdy_mode = 1;
      for (int c = 0; c < 10; c++) begin
         gen_words($urandom_range(0, 2), 0, 0);
         run_cw(($urandom_range(0, 2) * 0) + ((cw_words.size() / 60) - 1), 1, 0);
      end
      compare_all("random");
      rdy_mode = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/qcldpc_info_blk_packer.md
# qcldpc_info_blk_packer

Upstream feeder for the QC-LDPC encoder. It accepts a narrow IN_W-bit information stream with a valid/ready handshake and packs it into Z-bit information blocks, where Z is one of the supported lifting sizes. Each codeword consists of exactly NUM_INFO_BLKS blocks. Blocks are presented one per handshake on the encoder's MAX_Z-wide info-block input, together with the block index, first/last markers and the Z selection for that block.

## Interface
Parameters:
- NUM_Z, 3: number of supported lifting sizes.
- MAX_Z, 81: widest supported Z and the output block width.
- NUM_INFO_BLKS, 20: information blocks per codeword.
- IN_W, 9: input word width. Every Z_VALUES entry must be a multiple of IN_W; otherwise elaboration fails with $fatal.
- Z_VALUES[NUM_Z], {27, 54, 81}: Z for each req_z bit position.

Ports:
- CLK, in, 1: sole clock. Everything is rising-edge.
- rst, in, 1: reset, asynchronous and active-high.
- req_z, in, NUM_Z: one-hot Z select, sampled only at codeword start.
- s_data, in, IN_W: information word.
- s_valid, in, 1: s_data valid.
- s_ready, out, 1: word accepted on the edge where s_valid && s_ready.
- blk_data, out, MAX_Z: packed block. Bits [Z-1:0] carry data; bits [MAX_Z-1:Z] are 0.
- blk_valid, out, 1: block present.
- blk_ready, in, 1: consumer takes the block on the edge where blk_valid && blk_ready.
- blk_idx, out, $clog2(NUM_INFO_BLKS): block index within the codeword, 0..NUM_INFO_BLKS-1.
- blk_first, out, 1: high when blk_idx == 0.
- blk_last, out, 1: high when blk_idx == NUM_INFO_BLKS-1.
- blk_z, out, NUM_Z: one-hot Z of the presented block.
- cfg_err, out, 1: one-cycle pulse on a rejected codeword start.

## Operation
- State machine: IDLE, FILL.
- IDLE:
  - s_ready = 0.
  - If s_valid and req_z is one-hot: latch req_z into cur_z, compute WPB = Z/IN_W, clear w_cnt and b_cnt, go to FILL. The word stays on the bus and is accepted in FILL.
  - If s_valid and req_z is not one-hot (zero or multi-hot): pulse cfg_err for 1 cycle and stay in IDLE. The check repeats each cycle while s_valid is held.
- FILL:
  - s_ready = !pending.
  - An accepted word goes to fill buffer bits [w_cnt*IN_W +: IN_W]; word 0 lands at the LSBs. w_cnt then increments.
  - The accept with w_cnt == WPB-1 is the fill_done event.
- Transfer on fill_done:
  - If the output slot is free (blk_valid == 0, or blk_valid && blk_ready this cycle), the complete block, including the word accepted on this edge, loads the output register on the same edge. Bits above Z are zeroed.
  - Otherwise pending is set; the block waits in the fill buffer and s_ready = 0.
  - While pending, the transfer happens on the first edge where the slot frees up; pending then clears.
- A transfer loads blk_idx = b_cnt and blk_z = cur_z, sets blk_valid, increments b_cnt and clears w_cnt.
- On the transfer of block NUM_INFO_BLKS-1, go to IDLE. The output register may still hold that block while the next codeword starts; blk_z and blk_idx travel with each block.
- blk_valid falls on a consuming edge unless a new transfer happens on the same edge.
- req_z changes during FILL are ignored.
- Reset (asynchronous, any time, including mid-codeword):
  - state = IDLE.
  - All counters, pending and the fill buffer clear.
  - Outputs: s_ready = 0, blk_valid = 0, blk_data = 0, blk_idx = 0, blk_first = 0, blk_last = 0, blk_z = 0, cfg_err = 0.
  - Partial blocks and codewords are discarded. No output appears until a new codeword start.

## Timing
- Codeword start: 1 IDLE cycle, then the first word can be accepted.
- Latency: a block's last word accepted at edge k gives blk_valid = 1 after edge k, provided the slot is free.
- Throughput: 1 word/cycle sustained with blk_ready held high. A codeword takes NUM_INFO_BLKS*WPB + 1 cycles.
- Buffering is two-deep: one output block plus one completed block in the fill buffer.
- Under backpressure, blk_data, blk_idx, blk_first, blk_last and blk_z stay stable while blk_valid && !blk_ready.
- A consume and a transfer on the same edge are legal and produce no bubble.

## Test plan
- Z = 27 (req_z = 3'b001), s_data = 0..59 incrementing, blk_ready = 1:
  - 20 blocks; block 0 blk_data = 81'h80200, block 1 = {9'd5, 9'd4, 9'd3}, bits [80:27] = 0.
  - blk_first only at idx 0, blk_last only at idx 19, blk_z = 3'b001 throughout.
- Z = 81 codeword immediately followed by a Z = 54 codeword:
  - blocks 0–19 carry blk_z = 3'b100, then blocks 0–19 carry blk_z = 3'b010.
  - Z = 54 blocks have bits [80:54] = 0.
  - Exactly one IDLE cycle between the codewords.
- Z = 27, blk_ready = 0 from block 0 onward:
  - s_ready falls after word 5 (block 1 pending); blk_data holds block 0.
  - Release blk_ready: blocks 0 and 1 arrive in order, s_ready returns after block 1 transfers, no word is lost or duplicated.
- req_z = 3'b011 with s_valid = 1 for 3 cycles, then 3'b001: cfg_err pulses each of the 3 cycles, no word accepted, then a normal codeword follows.
- Assert rst for 1 cycle after word 40 of a Z = 27 codeword:
  - All outputs read 0 immediately.
  - A fresh codeword then produces blk_idx 0 containing the first post-reset words.
- Random blk_ready (50%) and s_valid (70%) over 10 codewords with mixed Z: scoreboard the packed data, blk_idx sequence and blk_z against a reference model.
